seq_gen: RTL and testbench

Serial pattern transmitter that drives the single-bit `d` stream consumed by the sequence-detector blocks (`seq_shift`, `seq_sm`). It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock. Programmable idle gap cycles separate words. An optional reference output, `exp_match`, pulses whenever the last four bits driven on `d` were 1,0,1,1, so detector outputs can be checked cycle-by-cycle.

---
 rtl/seq_gen_if.sv | 23 ++
 rtl/seq_gen.sv | 111 +++++++++++
 tb/tb_seq_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seq_gen_if.sv
// Word handshake plus serial-stream bundle for seq_gen.
// The master supplies words and watches the stream. The slave is the transmitter.
interface seq_gen_if #(
  parameter int W = 8
);
  logic         word_valid;
  logic         word_ready;
  logic [W-1:0] word_data;
  logic         d;
  logic         d_valid;
  logic         exp_match;
  logic [15:0]  word_cnt;

  modport master (
    output word_valid, word_data,
    input  word_ready, d, d_valid, exp_match, word_cnt
  );

  modport slave (
    input  word_valid, word_data,
    output word_ready, d, d_valid, exp_match, word_cnt
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: takes parallel words over valid/ready and sends them MSB-first on d.
// Defining SEQ_GEN_EXP_MATCH_EN builds the 1011 reference detector that drives exp_match.
module seq_gen #(
  parameter int W   = 8,
  parameter int GAP = 0
) (
  input  logic     i_clk,
  input  logic     i_reset,
  seq_gen_if.slave bus
);

  localparam int             CW       = $clog2(W);
  localparam logic [CW-1:0]  LAST_IDX = CW'(W - 1);
  localparam logic [3:0]     GAP_LD   = 4'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_shift;
  logic [CW-1:0]   r_bit_cnt;
  logic [3:0]      r_gap_cnt;
  logic [15:0]     r_word_cnt;
  logic            r_d_valid;
  logic            w_last;
  logic            w_ready;
  logic            w_accept;
  logic            w_d;

  assign w_last   = (r_state == S_SHIFT) && (r_bit_cnt == '0);
  assign w_accept = bus.word_valid && w_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_bit_cnt == '0) begin
          if (GAP > 0)       w_state_nxt = S_GAP;
          else if (w_accept) w_state_nxt = S_SHIFT;
          else               w_state_nxt = S_IDLE;
        end
      end
      S_GAP:   if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With no gap configured, the last-bit cycle also accepts, so words go out back-to-back.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_SHIFT: w_ready = (GAP == 0) && (r_bit_cnt == '0);
      default: w_ready = 1'b0;
    endcase
  end

  // Zeros shift in behind the word, so the MSB is already 0 when the block leaves SHIFT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_word_cnt <= '0;
      r_d_valid  <= 1'b0;
    end else begin
      r_d_valid <= (w_state_nxt == S_SHIFT);
      if (w_accept) begin
        r_shift   <= bus.word_data;
        r_bit_cnt <= LAST_IDX;
      end else if (r_state == S_SHIFT) begin
        r_shift   <= {r_shift[W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if (w_last) begin
        r_word_cnt <= r_word_cnt + 16'd1;
        r_gap_cnt  <= GAP_LD;
      end else if (r_state == S_GAP) begin
        r_gap_cnt  <= r_gap_cnt - 4'd1;
      end
    end
  end

  assign w_d = r_shift[W-1];

`ifdef SEQ_GEN_EXP_MATCH_EN
  // The history also samples idle and gap zeros, because a detector samples d every cycle.
  logic [2:0] r_hist;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_hist <= '0;
    else         r_hist <= {r_hist[1:0], w_d};
  end

  assign bus.exp_match = (r_hist == 3'b101) && w_d;
`else
  assign bus.exp_match = 1'b0;
`endif

  assign bus.d          = w_d;
  assign bus.d_valid    = r_d_valid;
  assign bus.word_ready = w_ready;
  assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen (W=8): a vector table for GAP=0 traffic, plus hand-written gap and reset sequences.
module tb_seq_gen;

`ifdef SEQ_GEN_EXP_MATCH_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [7:0]  data;
    logic        d;
    logic        dv;
    logic        rdy;
    logic        m;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  seq_gen_if #(.W(8)) if0 ();
  seq_gen_if #(.W(8)) if3 ();

  seq_gen #(.W(8), .GAP(0)) u0 (.i_clk(clk), .i_reset(reset), .bus(if0));
  seq_gen #(.W(8), .GAP(3)) u3 (.i_clk(clk), .i_reset(reset), .bus(if3));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] data, input logic d,
                              input logic dv, input logic rdy, input logic m,
                              input logic [15:0] cnt);
    vec_t r;
    r.v = v; r.data = data; r.d = d; r.dv = dv; r.rdy = rdy; r.m = m; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic d, input logic dv,
                     input logic rdy, input logic m, input logic [15:0] cnt);
    logic [19:0] exp;
    exp = {d, dv, rdy, m & EXP_EN, cnt};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got d=%b dv=%b rdy=%b m=%b cnt=%0d, expected d=%b dv=%b rdy=%b m=%b cnt=%0d",
               nm, act[19], act[18], act[17], act[16], act[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  function automatic logic [19:0] obs0();
    return {if0.d, if0.d_valid, if0.word_ready, if0.exp_match, if0.word_cnt};
  endfunction

  function automatic logic [19:0] obs3();
    return {if3.d, if3.d_valid, if3.word_ready, if3.exp_match, if3.word_cnt};
  endfunction

  vec_t tbl [35];

  initial begin
    logic [7:0] b0;
    int p;
    b0 = 8'hB0;
    // single word B0
    tbl[0]  = mk(1, 8'hB0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 1, 1, 0, 1, 0);
    tbl[4]  = mk(0, 8'h00, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 0, 1);
    // back-to-back 0B then B0, valid held until B0 is taken
    tbl[9]  = mk(1, 8'h0B, 0, 1, 0, 0, 1);
    tbl[10] = mk(1, 8'hB0, 0, 1, 0, 0, 1);
    tbl[11] = mk(1, 8'hB0, 0, 1, 0, 0, 1);
    tbl[12] = mk(1, 8'hB0, 0, 1, 0, 0, 1);
    tbl[13] = mk(1, 8'hB0, 1, 1, 0, 0, 1);
    tbl[14] = mk(1, 8'hB0, 0, 1, 0, 0, 1);
    tbl[15] = mk(1, 8'hB0, 1, 1, 0, 0, 1);
    tbl[16] = mk(1, 8'hB0, 1, 1, 1, 1, 1);
    tbl[17] = mk(1, 8'hB0, 1, 1, 0, 0, 2);
    tbl[18] = mk(0, 8'h00, 0, 1, 0, 0, 2);
    tbl[19] = mk(0, 8'h00, 1, 1, 0, 0, 2);
    tbl[20] = mk(0, 8'h00, 1, 1, 0, 1, 2);
    tbl[21] = mk(0, 8'h00, 0, 1, 0, 0, 2);
    tbl[22] = mk(0, 8'h00, 0, 1, 0, 0, 2);
    tbl[23] = mk(0, 8'h00, 0, 1, 0, 0, 2);
    tbl[24] = mk(0, 8'h00, 0, 1, 1, 0, 2);
    tbl[25] = mk(0, 8'h00, 0, 0, 1, 0, 3);
    // overlapping pattern B6 = 1011_0110
    tbl[26] = mk(1, 8'hB6, 1, 1, 0, 0, 3);
    tbl[27] = mk(0, 8'h00, 0, 1, 0, 0, 3);
    tbl[28] = mk(0, 8'h00, 1, 1, 0, 0, 3);
    tbl[29] = mk(0, 8'h00, 1, 1, 0, 1, 3);
    tbl[30] = mk(0, 8'h00, 0, 1, 0, 0, 3);
    tbl[31] = mk(0, 8'h00, 1, 1, 0, 0, 3);
    tbl[32] = mk(0, 8'h00, 1, 1, 0, 1, 3);
    tbl[33] = mk(0, 8'h00, 0, 1, 1, 0, 3);
    tbl[34] = mk(0, 8'h00, 0, 0, 1, 0, 4);

    if0.word_valid = 1'b0; if0.word_data = '0;
    if3.word_valid = 1'b0; if3.word_data = '0;

    // reset held for 3 cycles
    reset = 1'b1;
    repeat (3) step();
    chk("reset_u0", obs0(), 0, 0, 1, 0, 0);
    chk("reset_u3", obs3(), 0, 0, 1, 0, 0);
    reset = 1'b0;
    step();
    chk("idle_u0", obs0(), 0, 0, 1, 0, 0);

    for (int i = 0; i < 35; i++) begin
      if0.word_valid = tbl[i].v;
      if0.word_data  = tbl[i].data;
      step();
      chk($sformatf("vec%0d", i), obs0(), tbl[i].d, tbl[i].dv, tbl[i].rdy, tbl[i].m, tbl[i].cnt);
    end
    if0.word_valid = 1'b0;

    // GAP=3 with valid held high: 8 bits, 3 gap cycles, 1 idle cycle, repeat
    if3.word_valid = 1'b1;
    if3.word_data  = 8'hFF;
    for (int k = 1; k <= 24; k++) begin
      step();
      p = (k - 1) % 12;
      chk($sformatf("gap_k%0d", k), obs3(), p < 8, p < 8, (p == 7) ? 1'b0 : (p == 11),
          0, 16'((k + 3) / 12));
    end
    if3.word_valid = 1'b0;

    // reset during bit 5 of B0 aborts the word
    if0.word_valid = 1'b1; if0.word_data = 8'hB0;
    step();
    if0.word_valid = 1'b0; if0.word_data = 8'h00;
    repeat (4) step();
    chk("pre_abort_bit5", obs0(), 0, 1, 0, 0, 4);
    reset = 1'b1;
    step();
    chk("abort_reset", obs0(), 0, 0, 1, 0, 0);
    reset = 1'b0;
    repeat (2) step();
    chk("abort_idle", obs0(), 0, 0, 1, 0, 0);

    if0.word_valid = 1'b1; if0.word_data = 8'hB0;
    for (int i = 0; i < 8; i++) begin
      step();
      if0.word_valid = 1'b0;
      chk($sformatf("resend_bit%0d", i + 1), obs0(), b0[7-i], 1, i == 7, i == 3, 0);
    end
    step();
    chk("resend_done", obs0(), 0, 0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
